// File: rtl/dmem_hs_if.sv
// Request/response bus between the load/store stage (master) and dmem_hs (slave).
interface dmem_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W/8-1:0]   req_be;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_hs.sv
// Single-port data memory with valid/ready handshake, byte-lane writes,
// configurable access latency and misaligned / out-of-range fault reporting.
// One request is outstanding at a time: IDLE accepts, WAIT burns latency,
// RESP holds the response until the consumer takes it.
module dmem_hs #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 32,
  parameter int LATENCY   = 1,
  parameter int INIT_MODE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  dmem_hs_if.slave    bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cntNext;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic [ADDR_W-1:0]   w_wordIdx;
  logic                w_misaligned;
  logic                w_outOfRange;
  logic                w_fault;
  logic                w_accept;
  logic                w_wrEn;
  logic [DATA_W-1:0]   w_words [DEPTH];

  // Address decode: word index plus the two fault conditions. DEPTH is a
  // power of two, so anything above the index bits means out of range.
  assign w_wordIdx    = bus.req_addr >> OFF_W;
  assign w_misaligned = (bus.req_addr & ADDR_W'(NB - 1)) != '0;
  assign w_outOfRange = (w_wordIdx >> IDX_W) != '0;
  assign w_fault      = w_misaligned || w_outOfRange;

  // Accept is blocked while reset is held so a clock edge during reset
  // cannot sneak a write into the array.
  assign w_accept = i_rst_n && bus.req_valid && (r_state == IDLE);
  assign w_wrEn   = w_accept && bus.req_we && !w_fault;

  // Handshake flags come straight from the state register.
  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // Storage: one register per word, power-up image chosen by INIT_MODE and
  // loaded with the configuration, deliberately not touched by reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DATA_W-1:0] r_word = (INIT_MODE != 0) ? DATA_W'(gi) : '0;

    // Byte-lane merge of an accepted, non-faulting write to this word.
    always_ff @(posedge i_clk) begin
      if (w_wrEn && (w_wordIdx[IDX_W-1:0] == IDX_W'(gi))) begin
        for (int k = 0; k < NB; k++) begin
          if (bus.req_be[k]) begin
            r_word[8*k +: 8] <= bus.req_wdata[8*k +: 8];
          end
        end
      end
    end

    assign w_words[gi] = r_word;
  end

  // State and latency counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, drain in RESP.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_stateNext = RESP;
          end else begin
            w_stateNext = WAIT;
            w_cntNext   = 3'(LATENCY > 1 ? LATENCY - 2 : 0);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_stateNext = RESP;
        end else begin
          w_cntNext = r_cnt - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = 3'd0;
      end
    endcase
  end

  // Response register: captured on accept (read data sampled at that edge),
  // then frozen until the next accept, which keeps it stable under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err   <= w_fault;
      r_rdata <= (w_fault || bus.req_we) ? '0 : w_words[w_wordIdx[IDX_W-1:0]];
    end
  end

endmodule
